// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display showing a 32-bit value as hex.
// Registered outputs lag the slot counter by one cycle; the value is captured once per frame.
module seg7_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17,
  parameter int DEAD        = 4,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  output logic [7:0]  anode,
  output logic [6:0]  cathode
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      snap;
  logic [31:0]      upper;
  logic [3:0]       nib;
  logic             blank;
  logic             slot_end;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Shifting the current digit down to bit 0 gives both the nibble and
  // the "everything above is zero" test for leading-zero blanking.
  always_comb begin
    upper    = snap >> {idx, 2'b00};
    nib      = upper[3:0];
    blank    = (BLANK_LZ != 0) && (idx != 3'd0) && (upper == 32'h0);
    slot_end = (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      idx     <= 3'd0;
      snap    <= 32'h0;
      anode   <= 8'hFF;
      cathode <= 7'h7F;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= idx + 3'd1;
        // Capture only at frame end so a scan never mixes two values.
        if (idx == 3'd7)
          snap <= din;
      end
      anode   <= ((cnt < DEAD_C) || blank) ? 8'hFF : ~(8'h01 << idx);
      cathode <= blank ? 7'h7F : hex7(nib);
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux with blanking on (dut) and off (dut_nb), small refresh divider.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = 32'h0;
  logic [7:0]  anode, anode_nb;
  logic [6:0]  cathode, cathode_nb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(.REFRESH_DIV(8), .CNT_W(3), .DEAD(2), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .din(din), .anode(anode), .cathode(cathode));
  seg7_scan_mux #(.REFRESH_DIV(8), .CNT_W(3), .DEAD(2), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .reset(reset), .din(din), .anode(anode_nb), .cathode(cathode_nb));

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] ca;
    logic [7:0] an_nb;
    logic [6:0] ca_nb;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] hex_tab [16];
  int         m_cnt, m_idx;
  logic [31:0] m_snap;

  logic [6:0] cath_seen [8], cath_seen_nb [8];
  int         lows [8], lows_nb [8];
  logic [7:0] first_low;
  logic [6:0] exp_f2 [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Highest non-zero digit position; digits above it are leading zeros.
  function automatic int lead_digit(input logic [31:0] v);
    int   l;
    logic [31:0] t;
    l = 0;
    t = v;
    for (int k = 0; k < 8; k++) begin
      if (t[3:0] != 4'h0) l = k;
      t = t >> 4;
    end
    return l;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [31:0] t;
    logic [3:0]  n;
    logic        bl;
    t = m_snap;
    for (int k = 0; k < m_idx; k++) t = t >> 4;
    n  = t[3:0];
    bl = (m_idx > lead_digit(m_snap));
    if (reset) begin
      e = '{8'hFF, 7'h7F, 8'hFF, 7'h7F};
    end else begin
      e.an    = (m_cnt < 2 || bl) ? 8'hFF : ~(8'h01 << m_idx);
      e.ca    = bl ? 7'h7F : hex_tab[n];
      e.an_nb = (m_cnt < 2) ? 8'hFF : ~(8'h01 << m_idx);
      e.ca_nb = hex_tab[n];
    end
    return e;
  endfunction

  task automatic step();
    exp_t e;
    sb.push_back(predict());
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_idx = 0; m_snap = 32'h0;
    end else if (m_cnt == 7) begin
      if (m_idx == 7) m_snap = din;
      m_cnt = 0;
      m_idx = (m_idx + 1) % 8;
    end else begin
      m_cnt++;
    end
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("anode", {24'h0, anode}, {24'h0, e.an});
      chk("cathode", {25'h0, cathode}, {25'h0, e.ca});
      chk("anode_nb", {24'h0, anode_nb}, {24'h0, e.an_nb});
      chk("cathode_nb", {25'h0, cathode_nb}, {25'h0, e.ca_nb});
    end
    chk("onehot_low", {31'h0, ($countones(~anode) <= 1)}, 32'd1);
    chk("onehot_low_nb", {31'h0, ($countones(~anode_nb) <= 1)}, 32'd1);
  endtask

  task automatic run_frame(input int chg_at, input logic [31:0] chg_val);
    for (int k = 0; k < 8; k++) begin
      lows[k] = 0; lows_nb[k] = 0;
      cath_seen[k] = 7'h7F; cath_seen_nb[k] = 7'h7F;
    end
    first_low = 8'hFF;
    for (int t = 0; t < 64; t++) begin
      if (t == chg_at) din = chg_val;
      step();
      if (first_low == 8'hFF) first_low = anode;
      for (int k = 0; k < 8; k++) begin
        if (anode == ~(8'h01 << k)) begin lows[k]++; cath_seen[k] = cathode; end
        if (anode_nb == ~(8'h01 << k)) begin lows_nb[k]++; cath_seen_nb[k] = cathode_nb; end
      end
    end
  endtask

  task automatic chk_blanked_frame(input string tag, input logic [6:0] d0);
    chk({tag, "_d0_cath"}, {25'h0, cath_seen[0]}, {25'h0, d0});
    chk({tag, "_d0_lows"}, lows[0], 6);
    for (int k = 1; k < 8; k++) chk({tag, "_blank_lows"}, lows[k], 0);
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    exp_f2  = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    m_cnt = 0; m_idx = 0; m_snap = 32'h0;

    // Reset held three cycles with a non-zero input.
    reset = 1'b1;
    din   = 32'h1234_5678;
    repeat (3) step();
    chk("reset_anode", {24'h0, anode}, 32'hFF);
    chk("reset_cathode", {25'h0, cathode}, 32'h7F);
    reset = 1'b0;

    // Frame 1 still shows the reset snapshot of zero.
    run_frame(-1, 32'h0);
    chk_blanked_frame("f1", 7'h40);
    for (int k = 0; k < 8; k++) begin
      chk("f1_nb_cath", {25'h0, cath_seen_nb[k]}, 32'h40);
      chk("f1_nb_lows", lows_nb[k], 6);
    end

    // Frame 2 shows 12345678; A5 is captured at its end.
    din = 32'h0000_00A5;
    run_frame(-1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      chk("f2_cath", {25'h0, cath_seen[k]}, {25'h0, exp_f2[k]});
      chk("f2_lows", lows[k], 6);
    end

    // Frame 3 shows A5 with leading zeros blanked.
    din = 32'h0;
    run_frame(-1, 32'h0);
    chk("f3_d0_cath", {25'h0, cath_seen[0]}, 32'h12);
    chk("f3_d1_cath", {25'h0, cath_seen[1]}, 32'h08);
    chk("f3_d0_lows", lows[0], 6);
    chk("f3_d1_lows", lows[1], 6);
    for (int k = 2; k < 8; k++) begin
      chk("f3_blank_lows", lows[k], 0);
      chk("f3_nb_cath", {25'h0, cath_seen_nb[k]}, 32'h40);
    end

    // Frame 4 shows zero: one digit with blanking, all eight without.
    din = 32'h1111_1111;
    run_frame(-1, 32'h0);
    chk_blanked_frame("f4", 7'h40);
    for (int k = 0; k < 8; k++) chk("f4_nb_lows", lows_nb[k], 6);

    // Frame 5: input changes in slot 3 but the frame stays on 1s.
    run_frame(3 * 8 + 2, 32'h2222_2222);
    for (int k = 0; k < 8; k++) chk("f5_cath", {25'h0, cath_seen[k]}, 32'h79);

    run_frame(-1, 32'h0);
    for (int k = 0; k < 8; k++) chk("f6_cath", {25'h0, cath_seen[k]}, 32'h24);

    // Reset in slot 4, cycle 5.
    repeat (4 * 8 + 5) step();
    reset = 1'b1;
    step();
    chk("midreset_anode", {24'h0, anode}, 32'hFF);
    chk("midreset_cathode", {25'h0, cathode}, 32'h7F);
    reset = 1'b0;
    run_frame(-1, 32'h0);
    chk("restart_first_digit", {24'h0, first_low}, 32'hFE);
    chk_blanked_frame("f7", 7'h40);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
